// File: rtl/exec_issue_ctrl.sv
// Issue/hazard controller between decode and execute: valid/ready issue, operand
// forwarding from the execute result, long-op sequencing and registered write-back.
module exec_issue_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LONG_LAT = 4  // legal range 2..15; cnt is 4 bits wide
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic              dec_use_rd,
  input  logic              dec_use_rs,
  input  logic              dec_wr,
  input  logic              dec_long,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_stall,
  output logic              fwd_rd,
  output logic              fwd_rs,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(LONG_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [REG_AW-1:0] pend_rd, pend_rd_nxt;
  logic              pend_wr, pend_wr_nxt;
  logic              wb_en_nxt;
  logic [REG_AW-1:0] wb_addr_nxt;

  assign busy      = (state == BUSY);
  assign ex_stall  = busy;
  assign dec_ready = rst & ~busy;
  assign ex_valid  = dec_valid & dec_ready & ~flush;

  // The write-back registers hold the value retiring this cycle, which is exactly
  // what execute presents on data_o; a match means the operand is not yet in the file.
  assign fwd_rd = ex_valid & dec_use_rd & wb_en & (wb_addr == dec_rd);
  assign fwd_rs = ex_valid & dec_use_rs & wb_en & (wb_addr == dec_rs);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_rd_nxt = pend_rd;
    pend_wr_nxt = pend_wr;
    wb_en_nxt   = 1'b0;
    wb_addr_nxt = wb_addr;

    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          if (dec_long) begin
            state_nxt   = BUSY;
            cnt_nxt     = LAT_INIT;
            pend_rd_nxt = dec_rd;
            pend_wr_nxt = dec_wr;
          end else begin
            wb_en_nxt   = dec_wr;
            wb_addr_nxt = dec_rd;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        // Register the long-op write-back on the edge where cnt leaves 1, so it
        // lines up with the first cycle decode is allowed to issue again.
        if (cnt == 4'd1) begin
          state_nxt   = IDLE;
          wb_en_nxt   = pend_wr;
          wb_addr_nxt = pend_rd;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_rd <= '0;
      pend_wr <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_rd <= pend_rd_nxt;
      pend_wr <= pend_wr_nxt;
      wb_en   <= wb_en_nxt;
      wb_addr <= wb_addr_nxt;
    end
  end

endmodule

// File: doc/exec_issue_ctrl.md
# exec_issue_ctrl

Issue and hazard controller that sits between the decode stage and the `execute` unit. It accepts one decoded instruction per cycle over a valid/ready handshake and drives the execute issue strobe. It selects per-operand forwarding from `data_o` instead of the register file and sequences multi-cycle ("long") operations by stalling decode until their result is available. It also generates the registered register-file write-back strobe and address.

## Interface
Parameters:
- `REG_AW`, 5, register index width.
- `LONG_LAT`, 4, cycles a long op occupies execute; legal range 2..15.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst=0` resets).
- `dec_valid`  in  1  decode presents an instruction.
- `dec_ready`  out  1  controller accepts the instruction this cycle.
- `dec_rd`  in  REG_AW  destination / first-source register index.
- `dec_rs`  in  REG_AW  second-source register index.
- `dec_use_rd`  in  1  instruction reads `rd` as a source (two-address ALU op).
- `dec_use_rs`  in  1  instruction reads `rs`; decode drives this as `~immf`.
- `dec_wr`  in  1  instruction writes `rd`.
- `dec_long`  in  1  instruction is multi-cycle.
- `flush`  in  1  squash the instruction currently presented by decode.
- `ex_valid`  out  1  execute inputs are valid this cycle (issue strobe).
- `ex_stall`  out  1  execute must hold its internal long-op state.
- `fwd_rd`  out  1  execute takes the `rd` operand from `data_o`.
- `fwd_rs`  out  1  execute takes the `rs` operand from `data_o`.
- `wb_en`  out  1  register file writes `data_o` this cycle.
- `wb_addr`  out  REG_AW  write-back register index.
- `busy`  out  1  a long op is in flight.

## Operation
- The controller has two states:
  - `IDLE`: `busy=0`.
  - `BUSY`: `busy=1`, 4-bit down-counter `cnt` active.
- `dec_ready = rst & ~busy`.
- `ex_valid = dec_valid & dec_ready & ~flush`. A flushed instruction is consumed (`dec_ready` stays high) but never issued.
- Short-op issue at cycle t:
  - The result is in `data_o` at t+1.
  - `wb_en=dec_wr` and `wb_addr=dec_rd` at t+1. Both are registered, captured at the issue edge.
- Long-op issue at cycle t:
  - `IDLE` → `BUSY`, with `cnt` loaded to `LONG_LAT-1` and the pending destination/write flag latched.
  - In `BUSY`, `cnt` decrements every cycle and the state returns to `IDLE` when `cnt` reaches 0.
  - `ex_stall=busy`.
  - `wb_en`/`wb_addr` are asserted at t+LONG_LAT, registered on the edge where `cnt==1`.
- Forwarding, evaluated combinationally on the issuing cycle:
  - `fwd_rd = ex_valid & dec_use_rd & wb_en & (wb_addr==dec_rd)`.
  - `fwd_rs` is the same rule using `dec_use_rs` and `dec_rs`.
  - Both are 0 when not issuing.
- Every index, including 0, is an ordinary register: there is no hardwired zero.
- The register file is written at the end of the `wb_en` cycle and reads combinationally. Distance-2 dependencies therefore read the register file and need no forwarding.
- `flush` has no effect on an in-flight long op; its write-back still occurs. While `busy`, decode is already stalled and `flush` only gates `ex_valid` (already 0).
- Reset while `BUSY` aborts the long op: the state returns to `IDLE` and no write-back is produced.

## Timing
- Reset values: `busy=0`, `ex_stall=0`, `wb_en=0`, `wb_addr=0`, `cnt=0`, state `IDLE`.
- While `rst=0`, the combinational outputs are `dec_ready=0`, `ex_valid=0`, `fwd_rd=0`, `fwd_rs=0`.
- Short-op throughput is 1 per cycle; issue-to-write-back latency is 1 cycle.
- Long-op issue-to-write-back latency is `LONG_LAT` cycles. `dec_ready=0` for cycles t+1..t+LONG_LAT-1, and the next issue is possible at t+LONG_LAT, in the same cycle as the long op's `wb_en`, with forwarding.
- Issue and write-back in the same cycle is legal. The new issue forwards from the retiring write, while its own `wb_en` appears the next cycle.
- `wb_en` is never asserted for a squashed instruction or for an instruction with `dec_wr=0`.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles with `dec_valid=1` → `dec_ready=0`, `ex_valid=0`, `wb_en=0`, `wb_addr=0`, `busy=0`.
- **Back-to-back dependency:** short op writing r3 at t, then a short op at t+1 with `dec_rd=3`, `dec_use_rd=1`, `dec_rs=3`, `dec_use_rs=0` → at t+1 `fwd_rd=1`, `fwd_rs=0`, `wb_en=1`, `wb_addr=3`; at t+2 `wb_en=1`, `wb_addr=3`.
- **Long op:** long op writing r5 at t, `LONG_LAT=4`, `dec_valid` held high → `dec_ready=0` and `ex_stall=1` at t+1..t+3; at t+4 `wb_en=1`, `wb_addr=5`, `dec_ready=1`, and a dependent reader of r5 issues with `fwd_rs=1`.
- **Flush:** `flush=1` with `dec_valid=1` writing r7 → `dec_ready=1`, `ex_valid=0`, and `wb_en=0` the next cycle.
- **Reset mid-long-op:** long op at t, `rst=0` at t+2 → `busy=0` immediately, and no `wb_en` at t+4.
- **No-write op:** a short op with `dec_wr=0` followed by a reader of the same index → `wb_en=0`, `fwd_rd=0`, `fwd_rs=0`.
